// File: rtl/delay_pipe_arbiter.sv
// Round-robin arbiter that shares one fixed-latency delay pipeline among N_REQ requesters.
// Optional build macro DPA_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module delay_pipe_arbiter #(
  parameter int N_REQ   = 4,
  parameter int SIZE    = 8,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*SIZE-1:0]        req_data,
  input  logic                         flush,
  output logic [N_REQ-1:0]             gnt,
  output logic [SIZE-1:0]              pipe_din,
  input  logic [SIZE-1:0]              pipe_dout,
  output logic [N_REQ-1:0]             resp_vld,
  output logic [SIZE-1:0]              resp_data,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
  output logic                         drained
);

  localparam int IDW = $clog2(N_REQ);
  localparam int IW  = $clog2(LATENCY+1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             gnt_any;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic             tag_vld [LATENCY];
  logic [IDW-1:0]   tag_id  [LATENCY];
  logic [IW-1:0]    inflight_q;

`ifdef DPA_FIXED_PRIO_EN
  // Lowest asserted index wins; scanning downwards leaves the smallest index last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr;

  // Scan offsets downwards so the request nearest to ptr (smallest offset) is the one kept.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no latch is inferred.
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int off = N_REQ-1; off >= 0; off--) begin
      int idx;
      idx = (int'(ptr) + off) % N_REQ;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + IDW'(1);
    end
  end
`endif

  // Flush wins over any pending request; grants are also masked while reset is asserted.
  assign gnt_vld = gnt_any && (state == RUN) && !flush && !rst;

  always_comb begin
    gnt      = '0;
    pipe_din = '0;
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
      pipe_din     = req_data[int'(gnt_idx)*SIZE +: SIZE];
    end
  end

  always_comb begin
    state_nxt = state;
    drained   = 1'b0;
    case (state)
      RUN:   if (flush) state_nxt = DRAIN;
      DRAIN: if (inflight_q == '0 && !flush) begin
        state_nxt = RUN;
        drained   = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Tag shift register mirrors the external pipeline, one stage per cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tag stages are flops, not RAM, so they are reset; this discards words in flight.
      for (int k = 0; k < LATENCY; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= '0;
      end
    end else begin
      tag_vld[0] <= gnt_vld;
      tag_id[0]  <= gnt_idx;
      for (int k = 1; k < LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    resp_vld = '0;
    if (tag_vld[LATENCY-1]) resp_vld[tag_id[LATENCY-1]] = 1'b1;
  end

  assign resp_data = pipe_dout;

  // Occupancy is bounded by LATENCY, so the counter cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({gnt_vld, tag_vld[LATENCY-1]})
        2'b10:   inflight_q <= inflight_q + IW'(1);
        2'b01:   inflight_q <= inflight_q - IW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign inflight = inflight_q;

endmodule

// File: tb/tb_delay_pipe_arbiter.sv
// Randomized bench for delay_pipe_arbiter with an ideal 3-cycle pipeline and a queue-based reference model.
module tb_delay_pipe_arbiter;

  localparam int N_REQ   = 4;
  localparam int SIZE    = 8;
  localparam int LATENCY = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*SIZE-1:0]  req_data;
  logic                   flush;
  logic [N_REQ-1:0]       gnt;
  logic [SIZE-1:0]        pipe_din;
  logic [SIZE-1:0]        pipe_dout;
  logic [N_REQ-1:0]       resp_vld;
  logic [SIZE-1:0]        resp_data;
  logic [1:0]             inflight;
  logic                   drained;

  delay_pipe_arbiter #(.N_REQ(N_REQ), .SIZE(SIZE), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .flush(flush),
    .gnt(gnt), .pipe_din(pipe_din), .pipe_dout(pipe_dout), .resp_vld(resp_vld),
    .resp_data(resp_data), .inflight(inflight), .drained(drained)
  );

  always #5 clk = ~clk;

  // Ideal external delay pipeline.
  logic [SIZE-1:0] pipe_q [LATENCY];
  always @(posedge clk) begin
    pipe_q[0] <= pipe_din;
    for (int k = 1; k < LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign pipe_dout = pipe_q[LATENCY-1];

  typedef struct {
    int             id;
    logic [SIZE-1:0] data;
    int             due;
  } resp_t;

  resp_t q[$];
  int    m_ptr;
  bit    m_draining;
  int    cyc;
  int    n_checks;
  int    n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] r);
    int w;
    w = -1;
`ifdef DPA_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (w < 0 && r[i]) w = i;
`else
    for (int o = 0; o < N_REQ; o++) if (w < 0 && r[(m_ptr + o) % N_REQ]) w = (m_ptr + o) % N_REQ;
`endif
    return w;
  endfunction

  // Drive one cycle of inputs, check mid-cycle, then advance the model past the next edge.
  task automatic run_cycle(input logic [N_REQ-1:0] r, input logic [31:0] d, input logic f);
    int              w;
    int              exp_infl;
    logic [N_REQ-1:0] exp_gnt;
    logic [N_REQ-1:0] exp_rv;
    logic [SIZE-1:0]  exp_din;
    logic [SIZE-1:0]  exp_rd;
    req = r; req_data = d; flush = f;
    @(negedge clk);
    w        = (!m_draining && !f) ? pick(r) : -1;
    exp_gnt  = '0;
    exp_din  = '0;
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      exp_din    = d[w*SIZE +: SIZE];
    end
    exp_infl = q.size();
    exp_rv   = '0;
    exp_rd   = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv[q[0].id] = 1'b1;
      exp_rd          = q[0].data;
    end
    check("gnt",      32'(gnt),      32'(exp_gnt));
    check("pipe_din", 32'(pipe_din), 32'(exp_din));
    check("resp_vld", 32'(resp_vld), 32'(exp_rv));
    if (exp_rv != '0) check("resp_data", 32'(resp_data), 32'(exp_rd));
    check("inflight", 32'(inflight), 32'(exp_infl));
    check("drained",  32'(drained),  32'(m_draining && exp_infl == 0 && !f));
    if (exp_rv != '0) void'(q.pop_front());
    if (w >= 0) begin
      q.push_back('{id: w, data: exp_din, due: cyc + LATENCY});
      m_ptr = (w + 1) % N_REQ;
    end
    if (!m_draining && f) m_draining = 1'b1;
    else if (m_draining && exp_infl == 0 && !f) m_draining = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset mid-cycle and check the outputs clear without waiting for a clock edge.
  task automatic do_reset();
    req = '1; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_gnt",      32'(gnt),      32'(0));
    check("rst_resp_vld", 32'(resp_vld), 32'(0));
    check("rst_inflight", 32'(inflight), 32'(0));
    check("rst_drained",  32'(drained),  32'(0));
    q.delete();
    m_ptr = 0;
    m_draining = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc++;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    m_ptr = 0; m_draining = 1'b0;
    rst = 1'b1; req = '0; req_data = '0; flush = 1'b0;
    #1;
    check("init_gnt",      32'(gnt),      32'(0));
    check("init_resp_vld", 32'(resp_vld), 32'(0));
    check("init_inflight", 32'(inflight), 32'(0));
    check("init_pipe_din", 32'(pipe_din), 32'(0));
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;

    // Single request from requester 1 carrying 0x5A.
    run_cycle(4'b0010, 32'h0000_5A00, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(4'b0000, $urandom, 1'b0);

    // All requesters held: full-rate rotation.
    for (int i = 0; i < 8; i++) run_cycle(4'b1111, $urandom, 1'b0);

    // Flush after grants, then let it drain and resume.
    run_cycle(4'b1111, $urandom, 1'b1);
    for (int i = 0; i < 6; i++) run_cycle(4'b1111, $urandom, 1'b0);

    // Flush held well beyond the drain time.
    for (int i = 0; i < 7; i++) run_cycle(4'b0110, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(4'b0110, $urandom, 1'b0);

    // Build up two words in flight, then reset asynchronously.
    for (int i = 0; i < 6; i++) run_cycle(4'b0000, $urandom, 1'b0);
    run_cycle(4'b0001, $urandom, 1'b0);
    run_cycle(4'b0100, $urandom, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) run_cycle(4'b0000, $urandom, 1'b0);

    // Fixed pattern that starves requester 2 under fixed priority.
    for (int i = 0; i < 6; i++) run_cycle(4'b0101, $urandom, 1'b0);

    // Random traffic with occasional flushes and one more reset.
    for (int i = 0; i < 400; i++) begin
      run_cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 11) == 0));
      if (i == 200) do_reset();
    end
    for (int i = 0; i < 6; i++) run_cycle(4'b0000, $urandom, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
